bcd_accum: RTL and testbench
============================

# bcd_accum

Parametrised, digit-serial BCD adder/accumulator with per-digit seven-segment outputs. It generalises the single-digit BCD add-and-display path to NDIGITS digits. It processes one digit per clock under a start/busy/done handshake, and can optionally accumulate onto its own previous result. It sits between operand entry (switches/registers) and the board display drivers.

## Interface
- NDIGITS, 4: number of BCD digits (1–8); operand/result width is 4*NDIGITS bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a new operation; honoured only in IDLE.
- mode  in  1  0 = result := a + b + cin; 1 = result := result + b + cin (accumulate); sampled with start.
- a  in  4*NDIGITS  BCD operand, digit 0 in bits [3:0]; sampled with start.
- b  in  4*NDIGITS  BCD operand; sampled with start.
- cin  in  1  carry into digit 0; sampled with start.
- busy  out  1  high while digits are being processed.
- done  out  1  one-cycle pulse when result/cout/invalid update.
- result  out  4*NDIGITS  last completed BCD sum.
- cout  out  1  decimal carry out of the top digit of the last completed sum.
- invalid  out  1  last completed operation had any operand digit > 9.
- seg  out  8*NDIGITS  seven-segment pattern per result digit, {dp,g,f,e,d,c,b,a}, active-high.

## Operation
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On start=1, latch the operands. Operand A is `a` when mode=0, or the current `result` when mode=1.
  - Latch b, cin → carry register; clear the digit index and the invalid accumulator; go to ADD.
- ADD, one digit per cycle at index i:
  - s = A_i + B_i + carry (5-bit binary).
  - If s > 9: digit = (s + 6)[3:0], carry = 1. Otherwise digit = s[3:0], carry = 0.
  - Store the digit into working register slot i.
  - invalid_acc |= (A_i > 9) | (B_i > 9). Operand A is checked only when mode=0.
  - When i = NDIGITS-1, go to DONE; otherwise i++.
- DONE (one cycle):
  - Copy the working register → result, carry → cout, invalid_acc → invalid.
  - Pulse done; return to IDLE.
- start while busy or in DONE is ignored; it is not queued.
- Invalid inputs still produce a result computed by the rule above. Result digits can then exceed 9.
- seg decode per result digit:
  - 0–9 use standard patterns (0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F).
  - A digit > 9 shows 'E' (0x79).
  - dp of the top digit = cout; all other dp = 0.

## Timing
- Reset (asynchronous): FSM = IDLE, busy = 0, done = 0, result = 0, cout = 0, invalid = 0, internal registers = 0. seg therefore shows 0x3F on every digit.
- Latency: start sampled at edge k → busy high from edge k+1 through edge k+NDIGITS → done high and result valid after edge k+NDIGITS+1. Total NDIGITS+1 cycles.
- done is a single-cycle pulse and busy is low during DONE. The earliest next start is the cycle after done (back-to-back throughput NDIGITS+2 cycles).
- result, cout, invalid and seg are registered or derived combinationally from registers. They change only in DONE and hold until the next DONE or reset.
- Reset asserted mid-operation aborts it; no done is produced.
- Accumulate mode reads result as it stands at the start edge, including the reset value 0.

## Structure
- Package bcd_pkg holds:
  - SEG_* pattern constants and SEG_ERR = 0x79;
  - the FSM state enum;
  - the function/constant for the digit-index width ($clog2 of NDIGITS, minimum 1).
- Sub-module bcd_digit_add (combinational: 4-bit a, b, 1-bit ci → 4-bit digit, co, bad flag), instantiated once and time-multiplexed over digits.
- Sub-module seg7_decode (4-bit → 8-bit), generated NDIGITS times.

## Test plan
- NDIGITS=4, mode=0, a=0x1234, b=0x8766, cin=0 → done 5 cycles after start; result=0x0000, cout=1, invalid=0, top-digit dp=1.
- mode=0, a=0x0999, b=0x0001, cin=1 → result=0x1001, cout=0; seg digit 3 = 0x06, digit 0 = 0x06.
- After reset, three starts with mode=1, b=0x0250, cin=0 → result 0x0250, 0x0500, then 0x0750; cout=0 each time.
- mode=0, a=0x000F, b=0x0000 → invalid=1 after done; digit 0 = (15+6)[3:0] = 5 with carry, so result=0x0015.
- start asserted again during busy, with different operands → ignored; result matches the first request; exactly one done.
- rst asserted two cycles after start → busy=0, result=0, no done pulse; a new start then completes normally in 5 cycles.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD accumulator: seven-segment
// patterns, FSM state encoding and the digit-index width helper.
package bcd_pkg;

    localparam logic [7:0] SEG_0   = 8'h3F;
    localparam logic [7:0] SEG_1   = 8'h06;
    localparam logic [7:0] SEG_2   = 8'h5B;
    localparam logic [7:0] SEG_3   = 8'h4F;
    localparam logic [7:0] SEG_4   = 8'h66;
    localparam logic [7:0] SEG_5   = 8'h6D;
    localparam logic [7:0] SEG_6   = 8'h7D;
    localparam logic [7:0] SEG_7   = 8'h07;
    localparam logic [7:0] SEG_8   = 8'h7F;
    localparam logic [7:0] SEG_9   = 8'h6F;
    localparam logic [7:0] SEG_ERR = 8'h79;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-digit build still needs a 1-bit index register.
    function automatic int idx_width(input int ndigits);
        return (ndigits > 1) ? $clog2(ndigits) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit add with decimal correction; shared across all digits of
// the accumulator, one digit per clock.
module bcd_digit_add (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    input  logic       chk_a,
    output logic [3:0] digit,
    output logic       co,
    output logic       bad
);

    logic [4:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        // Adding 6 only affects the low nibble once the carry is taken out.
        if (s > 5'd9) begin
            digit = s[3:0] + 4'd6;
            co    = 1'b1;
        end else begin
            digit = s[3:0];
            co    = 1'b0;
        end
        bad = (chk_a & (a > 4'd9)) | (b > 4'd9);
    end

endmodule

// File: rtl/seg7_decode.sv
// BCD digit to seven-segment pattern {dp,g,f,e,d,c,b,a}; non-decimal
// digits display 'E'. The decimal point is left to the caller.
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_ERR;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bcd_accum.sv
// Digit-serial NDIGITS-wide BCD adder/accumulator with start/busy/done
// handshake and per-digit seven-segment outputs.
module bcd_accum
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   mode,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   result,
    output logic                   cout,
    output logic                   invalid,
    output logic [8*NDIGITS-1:0]   seg
);

    localparam int W  = 4 * NDIGITS;
    localparam int IW = idx_width(NDIGITS);

    state_t         state, state_nxt;
    logic [IW-1:0]  idx;
    logic [W-1:0]   opa, opb, work;
    logic           carry, inv_acc, chk_a;
    logic [3:0]     dsum;
    logic           dco, dbad;
    logic           last;

    assign last = (idx == IW'(NDIGITS - 1));
    assign busy = (state == ST_ADD);

    // Operands are shifted down so the adder always sees the current digit in [3:0].
    bcd_digit_add u_add (
        .a     (opa[3:0]),
        .b     (opb[3:0]),
        .ci    (carry),
        .chk_a (chk_a),
        .digit (dsum),
        .co    (dco),
        .bad   (dbad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ADD;
            ST_ADD:  if (last)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            opa     <= '0;
            opb     <= '0;
            work    <= '0;
            carry   <= 1'b0;
            inv_acc <= 1'b0;
            chk_a   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            invalid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa     <= mode ? result : a;
                        opb     <= b;
                        carry   <= cin;
                        chk_a   <= ~mode;
                        idx     <= '0;
                        inv_acc <= 1'b0;
                    end
                end
                ST_ADD: begin
                    opa               <= opa >> 4;
                    opb               <= opb >> 4;
                    work[4*idx +: 4]  <= dsum;
                    carry             <= dco;
                    inv_acc           <= inv_acc | dbad;
                    if (!last) idx <= idx + 1'b1;
                end
                ST_DONE: begin
                    result  <= work;
                    cout    <= carry;
                    invalid <= inv_acc;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only the most significant digit carries the decimal point, driven by cout.
    for (genvar g = 0; g < NDIGITS; g++) begin : g_seg
        logic [7:0] pat;
        seg7_decode u_dec (
            .digit (result[4*g +: 4]),
            .seg   (pat)
        );
        assign seg[8*g +: 8] = pat | {((g == NDIGITS - 1) & cout), 7'b0};
    end

endmodule

// File: tb/tb_bcd_accum.sv
// Randomised and directed bench for bcd_accum (NDIGITS=4) against a
// digit-rule reference model.
module tb_bcd_accum;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic           clk = 1'b0;
    logic           rst, start, mode, cin;
    logic [W-1:0]   a, b;
    logic           busy, done, cout, invalid;
    logic [W-1:0]   result;
    logic [8*N-1:0] seg;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [W-1:0] m_result;
    logic         m_cout, m_inv;

    logic [7:0] segtab [0:9] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    bcd_accum #(.NDIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
        .invalid(invalid), .seg(seg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        int cc;
        int s;
        logic [W-1:0] r;
        cc = int'(c);
        r = '0;
        for (int d = 0; d < N; d++) begin
            s = int'(x[4*d +: 4]) + int'(y[4*d +: 4]) + cc;
            if (s > 9) begin
                r[4*d +: 4] = 4'((s + 6) % 16);
                cc = 1;
            end else begin
                r[4*d +: 4] = 4'(s);
                cc = 0;
            end
        end
        return {cc[0], r};
    endfunction

    function automatic logic any_bad(input logic [W-1:0] x);
        logic r;
        r = 1'b0;
        for (int d = 0; d < N; d++) if (x[4*d +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic logic [8*N-1:0] ref_seg(input logic [W-1:0] r, input logic c);
        logic [8*N-1:0] s;
        for (int d = 0; d < N; d++)
            s[8*d +: 8] = (r[4*d +: 4] > 4'd9) ? 8'h79 : segtab[r[4*d +: 4]];
        s[8*N-1] = c;
        return s;
    endfunction

    task automatic model_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        logic [W-1:0] opa;
        opa = m ? m_result : x;
        {m_cout, m_result} = ref_sum(opa, y, c);
        m_inv = any_bad(y) | (!m && any_bad(x));
    endtask

    // Issues one operation, returns cycles from the start edge to done (0 on timeout).
    task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic c, output int lat, output int dones, output logic busy1);
        int d0;
        model_op(m, x, y, c);
        @(negedge clk);
        mode = m; a = x; b = y; cin = c; start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        busy1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) busy1 = busy;
            if (done === 1'b1) begin lat = i; break; end
        end
        repeat (2) @(negedge clk);
        dones = done_cnt - d0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        m_result = '0; m_cout = 1'b0; m_inv = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
        checks++; if ({cout, invalid} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {cout, invalid}); end
        checks++; if (seg !== 32'h3F3F3F3F) begin errors++; $display("FAIL reset_seg got %h exp 3f3f3f3f", seg); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        int lat, dn;
        logic b1;
        run_op(1'b0, 16'h1234, 16'h8766, 1'b0, lat, dn, b1);
        checks++; if (lat != N + 1) begin errors++; $display("FAIL dir1_latency got %0d exp %0d", lat, N + 1); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL dir1_busy got %b exp 1", b1); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL dir1_result got %h exp 0000", result); end
        checks++; if ({cout, invalid} !== 2'b10) begin errors++; $display("FAIL dir1_flags got %b exp 10", {cout, invalid}); end
        checks++; if (seg[31] !== 1'b1) begin errors++; $display("FAIL dir1_dp got %b exp 1", seg[31]); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir1_done_pulse got %b exp 0", done); end
        checks++; if (dn != 1) begin errors++; $display("FAIL dir1_done_count got %0d exp 1", dn); end

        run_op(1'b0, 16'h0999, 16'h0001, 1'b1, lat, dn, b1);
        checks++; if (result !== 16'h1001) begin errors++; $display("FAIL dir2_result got %h exp 1001", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL dir2_cout got %b exp 0", cout); end
        checks++; if (seg[31:24] !== 8'h06) begin errors++; $display("FAIL dir2_seg3 got %h exp 06", seg[31:24]); end
        checks++; if (seg[7:0] !== 8'h06) begin errors++; $display("FAIL dir2_seg0 got %h exp 06", seg[7:0]); end

        run_op(1'b0, 16'h9999, 16'h9999, 1'b1, lat, dn, b1);
        checks++; if ({cout, result} !== 17'h19999) begin errors++; $display("FAIL dir3_max got %h exp 19999", {cout, result}); end
        checks++; if (seg !== 32'hEF6F6F6F) begin errors++; $display("FAIL dir3_seg got %h exp ef6f6f6f", seg); end
    endtask

    task automatic test_accumulate;
        int lat, dn;
        logic b1;
        logic [W-1:0] exp_r [3] = '{16'h0250, 16'h0500, 16'h0750};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_result = '0; m_cout = 1'b0; m_inv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            run_op(1'b1, 16'h9999, 16'h0250, 1'b0, lat, dn, b1);
            checks++; if (result !== exp_r[k]) begin errors++; $display("FAIL accum_%0d got %h exp %h", k, result, exp_r[k]); end
            checks++; if (cout !== 1'b0) begin errors++; $display("FAIL accum_cout_%0d got %b exp 0", k, cout); end
        end
    endtask

    task automatic test_invalid;
        int lat, dn;
        logic b1;
        run_op(1'b0, 16'h000F, 16'h0000, 1'b0, lat, dn, b1);
        checks++; if (invalid !== 1'b1) begin errors++; $display("FAIL inv_flag got %b exp 1", invalid); end
        checks++; if (result !== 16'h0015) begin errors++; $display("FAIL inv_result got %h exp 0015", result); end
        run_op(1'b0, 16'h0003, 16'h0004, 1'b0, lat, dn, b1);
        checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL inv_clear got %b exp 0", invalid); end
        checks++; if (result !== 16'h0007) begin errors++; $display("FAIL inv_after got %h exp 0007", result); end
    endtask

    task automatic test_ignore_busy;
        int d0, lat;
        @(negedge clk);
        mode = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        a = 16'h5555; b = 16'h4444;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b0;
            if (done === 1'b1) begin lat = i; break; end
        end
        repeat (8) @(negedge clk);
        checks++; if (lat != N + 1) begin errors++; $display("FAIL busy_latency got %0d exp %0d", lat, N + 1); end
        checks++; if (result !== 16'h3333) begin errors++; $display("FAIL busy_result got %h exp 3333", result); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_done_count got %0d exp 1", done_cnt - d0); end
        m_result = 16'h3333; m_cout = 1'b0; m_inv = 1'b0;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        mode = 1'b0; a = 16'h0100; b = 16'h0200; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) break;
        end
        a = 16'h4000; b = 16'h0005; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin lat = i; break; end
        end
        checks++; if (lat != N + 1) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", lat, N + 1); end
        checks++; if (result !== 16'h4006) begin errors++; $display("FAIL b2b_result got %h exp 4006", result); end
        m_result = 16'h4006; m_cout = 1'b0; m_inv = 1'b0;
    endtask

    task automatic test_reset_abort;
        int d0, lat, dn;
        logic b1;
        @(negedge clk);
        mode = 1'b0; a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL abort_result got %h exp 0000", result); end
        @(negedge clk); rst = 1'b0;
        m_result = '0; m_cout = 1'b0; m_inv = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", done_cnt - d0); end
        run_op(1'b0, 16'h0042, 16'h0058, 1'b0, lat, dn, b1);
        checks++; if (lat != N + 1) begin errors++; $display("FAIL abort_relat got %0d exp %0d", lat, N + 1); end
        checks++; if (result !== 16'h0100) begin errors++; $display("FAIL abort_reresult got %h exp 0100", result); end
    endtask

    task automatic test_random;
        int lat, dn;
        logic b1, m, c;
        logic [W-1:0] x, y;
        for (int it = 0; it < 40; it++) begin
            m = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            for (int d = 0; d < N; d++) begin
                x[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
                y[4*d +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
            run_op(m, x, y, c, lat, dn, b1);
            checks++; if (lat != N + 1 || dn != 1) begin errors++; $display("FAIL rnd%0d_timing got lat %0d dones %0d exp %0d 1", it, lat, dn, N + 1); end
            checks++; if ({cout, result} !== {m_cout, m_result}) begin errors++; $display("FAIL rnd%0d_sum got %h exp %h", it, {cout, result}, {m_cout, m_result}); end
            checks++; if (invalid !== m_inv) begin errors++; $display("FAIL rnd%0d_invalid got %b exp %b", it, invalid, m_inv); end
            checks++; if (seg !== ref_seg(m_result, m_cout)) begin errors++; $display("FAIL rnd%0d_seg got %h exp %h", it, seg, ref_seg(m_result, m_cout)); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_accumulate();
        test_invalid();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
